// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: in-order register write-back FIFO with read-hit detection.
// Define WBQ_BYPASS_EN to forward the youngest matching entry's data on rdN_byp.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_addr,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      wr_hold,
  output logic                      Rwrite,
  output logic [ADDR_W-1:0]         Rdst_addr,
  output logic [DATA_W-1:0]         Rdst,
  input  logic [ADDR_W-1:0]         rd1_addr,
  input  logic [ADDR_W-1:0]         rd2_addr,
  output logic                      rd1_hit,
  output logic                      rd2_hit,
  output logic [DATA_W-1:0]         rd1_byp,
  output logic [DATA_W-1:0]         rd2_byp,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int AW = $clog2(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [AW-1:0]     head, tail, idx;
  logic [AW:0]       count;
  logic              push, pop, empty;

  assign empty     = count == '0;
  assign in_ready  = count < (AW+1)'(DEPTH);
  assign Rwrite    = !empty && !wr_hold;
  assign push      = in_valid && in_ready;
  assign pop       = Rwrite;
  assign Rdst_addr = empty ? '0 : addr_q[head];
  assign Rdst      = empty ? '0 : data_q[head];
  assign level     = count;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end

  always_ff @(posedge clk)
    if (push) begin
      addr_q[tail] <= in_addr;
      data_q[tail] <= in_data;
    end

  // Scan oldest to youngest so the last match wins as the youngest writer.
  always_comb begin
    rd1_hit = 1'b0;
    rd2_hit = 1'b0;
    rd1_byp = '0;
    rd2_byp = '0;
    idx     = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((AW+1)'(i) < count) begin
        if (addr_q[idx] == rd1_addr) begin
          rd1_hit = 1'b1;
`ifdef WBQ_BYPASS_EN
          rd1_byp = data_q[idx];
`endif
        end
        if (addr_q[idx] == rd2_addr) begin
          rd2_hit = 1'b1;
`ifdef WBQ_BYPASS_EN
          rd2_byp = data_q[idx];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: random and directed stimulus against a queue-based model.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4, DATA_W = 16, ADDR_W = 5;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, wr_hold = 0, Rwrite, rd1_hit, rd2_hit;
  logic [ADDR_W-1:0] in_addr = '0, Rdst_addr, rd1_addr = '0, rd2_addr = '0;
  logic [DATA_W-1:0] in_data = '0, Rdst, rd1_byp, rd2_byp;
  logic [$clog2(DEPTH):0] level;

  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } ent_t;
  ent_t q[$];
  int checks = 0, errors = 0;

  reg_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .wr_hold(wr_hold), .Rwrite(Rwrite),
    .Rdst_addr(Rdst_addr), .Rdst(Rdst), .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_hit(rd1_hit), .rd2_hit(rd2_hit), .rd1_byp(rd1_byp), .rd2_byp(rd2_byp),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic h1 = 0, h2 = 0;
    logic [DATA_W-1:0] b1 = '0, b2 = '0;
    foreach (q[i]) begin
      if (q[i].a == rd1_addr) begin h1 = 1; b1 = q[i].d; end
      if (q[i].a == rd2_addr) begin h2 = 1; b2 = q[i].d; end
    end
`ifndef WBQ_BYPASS_EN
    b1 = '0;
    b2 = '0;
`endif
    check("in_ready", in_ready, q.size() < DEPTH);
    check("Rwrite", Rwrite, q.size() != 0 && !wr_hold);
    check("Rdst_addr", Rdst_addr, q.size() != 0 ? q[0].a : '0);
    check("Rdst", Rdst, q.size() != 0 ? q[0].d : '0);
    check("level", level, q.size());
    check("rd1_hit", rd1_hit, h1);
    check("rd2_hit", rd2_hit, h2);
    check("rd1_byp", rd1_byp, b1);
    check("rd2_byp", rd2_byp, b2);
  endtask

  task automatic cycle();
    logic do_push, do_pop;
    @(negedge clk);
    check_model();
    do_push = in_valid && q.size() < DEPTH;
    do_pop  = q.size() != 0 && !wr_hold;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{in_addr, in_data});
    #1;
  endtask

  task automatic offer(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    in_valid = 1;
    in_addr  = a;
    in_data  = d;
    cycle();
    in_valid = 0;
  endtask

  task automatic drain();
    in_valid = 0;
    wr_hold  = 0;
    repeat (DEPTH + 2) cycle();
  endtask

  initial begin
    logic acc;
    int guard;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 1);
    check("rst_rwrite", Rwrite, 0);
    check("rst_level", level, 0);
    check("rst_rdst", Rdst, 0);
    @(negedge clk) rst_n = 1;
    cycle();

    offer(5'd3, 16'hA5A5);
    check("t1_rwrite", Rwrite, 1);
    check("t1_addr", Rdst_addr, 3);
    check("t1_data", Rdst, 16'hA5A5);
    cycle();
    check("t1_empty_rw", Rwrite, 0);
    check("t1_empty_lvl", level, 0);

    wr_hold = 1;
    for (int a = 1; a <= 4; a++) offer(ADDR_W'(a), DATA_W'($urandom));
    check("full_level", level, 4);
    check("full_ready", in_ready, 0);
    in_valid = 1;
    in_addr  = 5'd9;
    in_data  = 16'h9999;
    cycle();
    check("held_level", level, 4);
    wr_hold = 0;
    guard = 0;
    while (in_valid && guard < 10) begin
      acc = in_ready;
      cycle();
      if (acc) in_valid = 0;
      guard++;
    end
    check("held_accepted", in_valid, 0);
    drain();

    wr_hold  = 1;
    offer(5'd7, 16'h1111);
    offer(5'd7, 16'h2222);
    rd1_addr = 5'd7;
    rd2_addr = 5'd8;
    #1;
    check("dup_hit1", rd1_hit, 1);
    check("dup_hit2", rd2_hit, 0);
`ifdef WBQ_BYPASS_EN
    check("dup_byp1", rd1_byp, 16'h2222);
`else
    check("dup_byp1", rd1_byp, 0);
`endif
    cycle();
    drain();

    wr_hold = 1;
    offer(5'd0, 16'h0F0F);
    offer(5'd0, 16'hF0F0);
    wr_hold = 0;
    for (int i = 0; i < 2 * DEPTH + 3; i++) begin
      in_valid = 1;
      in_addr  = ADDR_W'($urandom_range(0, 7));
      in_data  = DATA_W'($urandom);
      cycle();
      check("steady_level", level, 2);
    end
    drain();

    wr_hold = 1;
    for (int a = 0; a < 3; a++) offer(ADDR_W'(a + 10), DATA_W'($urandom));
    wr_hold = 0;
    @(negedge clk);
    check("pre_rst_rw", Rwrite, 1);
    rst_n = 0;
    #1;
    check("mid_rst_rw", Rwrite, 0);
    check("mid_rst_lvl", level, 0);
    check("mid_rst_rdy", in_ready, 1);
    check("mid_rst_addr", Rdst_addr, 0);
    q.delete();
    @(negedge clk) rst_n = 1;
    repeat (4) cycle();

    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      wr_hold  = $urandom_range(0, 2) == 0;
      in_addr  = ADDR_W'($urandom_range(0, 7));
      in_data  = DATA_W'($urandom);
      rd1_addr = ADDR_W'($urandom_range(0, 7));
      rd2_addr = ADDR_W'($urandom_range(0, 7));
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
